// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: power-of-two depth, exact occupancy,
// programmable almost-full/almost-empty thresholds, sticky error flags and
// a selectable first-word-fall-through read mode.
module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    occ;
   logic             rd_ok;
   logic             wr_ok;

   // Status flags are decoded from the registered occupancy only.
   always_comb begin
      full         = (occ == FULL_CNT);
      empty        = (occ == '0);
      almost_full  = (occ >= AF_CNT);
      almost_empty = (occ <= AE_CNT);
      count        = occ;
   end

   // Accept logic: a write at full is allowed when a read frees a slot in the same cycle.
   always_comb begin
      rd_ok = rd_en && !empty;
      wr_ok = wr_en && (!full || rd_ok);
   end

   // Storage array; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy counter: simultaneous accepted read and write leave it unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ <= '0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Sticky error flags; a new error in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_ok)  overflow <= 1'b1;
         else if (clr_err)     overflow <= 1'b0;
         if (rd_en && !rd_ok)  underflow <= 1'b1;
         else if (clr_err)     underflow <= 1'b0;
      end
   end

   generate
      if (FWFT == 0) begin : g_std
         logic [WIDTH-1:0] dout_q;
         logic             valid_q;

         // Registered read: data appears one cycle after an accepted read, valid pulses once.
         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_ok;
               if (rd_ok) dout_q <= mem[rd_ptr];
            end
         end

         assign dout  = dout_q;
         assign valid = valid_q;
      end else begin : g_fwft
         // Head word is always presented; rd_en acts as the pop acknowledge.
         assign dout  = mem[rd_ptr];
         assign valid = !empty;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a DEPTH=4 standard-read instance and a
// DEPTH=4 first-word-fall-through instance share one clock.
module tb_sync_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Standard-mode instance
   logic       std_reset, std_wr_en, std_rd_en, std_clr_err;
   logic [7:0] std_din, std_dout;
   logic       std_valid, std_full, std_empty, std_af, std_ae, std_ovf, std_unf;
   logic [2:0] std_count;

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_std (
      .clk(clk), .reset(std_reset), .wr_en(std_wr_en), .din(std_din), .rd_en(std_rd_en),
      .dout(std_dout), .valid(std_valid), .full(std_full), .empty(std_empty),
      .almost_full(std_af), .almost_empty(std_ae), .count(std_count),
      .overflow(std_ovf), .underflow(std_unf), .clr_err(std_clr_err));

   // FWFT instance
   logic       fw_reset, fw_wr_en, fw_rd_en, fw_clr_err;
   logic [7:0] fw_din, fw_dout;
   logic       fw_valid, fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf;
   logic [2:0] fw_count;

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fw (
      .clk(clk), .reset(fw_reset), .wr_en(fw_wr_en), .din(fw_din), .rd_en(fw_rd_en),
      .dout(fw_dout), .valid(fw_valid), .full(fw_full), .empty(fw_empty),
      .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
      .overflow(fw_ovf), .underflow(fw_unf), .clr_err(fw_clr_err));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      std_reset = 1'b1; std_wr_en = 1'b0; std_rd_en = 1'b0; std_clr_err = 1'b0; std_din = 8'h00;
      fw_reset  = 1'b1; fw_wr_en  = 1'b0; fw_rd_en  = 1'b0; fw_clr_err  = 1'b0; fw_din  = 8'h00;
      step(); step();
      std_reset = 1'b0; fw_reset = 1'b0;
      checks++; if (std_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", std_count); end
      checks++; if (std_dout !== 8'h00) begin fails++; $display("FAIL rst_dout got %h exp 00", std_dout); end
      checks++; if (std_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", std_valid); end
      checks++; if ({std_empty, std_full, std_ae, std_af} !== 4'b1010) begin fails++; $display("FAIL rst_flags got %b exp 1010", {std_empty, std_full, std_ae, std_af}); end
      checks++; if ({std_ovf, std_unf} !== 2'b00) begin fails++; $display("FAIL rst_err got %b exp 00", {std_ovf, std_unf}); end
      checks++; if ({fw_valid, fw_empty, fw_count} !== 5'b01000) begin fails++; $display("FAIL rst_fw got %b exp 01000", {fw_valid, fw_empty, fw_count}); end
   endtask

   task automatic test_fill_drain();
      logic [7:0] data [4];
      data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
      std_wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         std_din = data[i];
         step();
         checks++; if (std_count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count got %0d exp %0d", std_count, i + 1); end
         checks++; if (std_af !== (i >= 2)) begin fails++; $display("FAIL fill_af got %b exp %b", std_af, (i >= 2)); end
         checks++; if (std_ae !== (i == 0)) begin fails++; $display("FAIL fill_ae got %b exp %b", std_ae, (i == 0)); end
      end
      std_wr_en = 1'b0;
      checks++; if ({std_full, std_empty} !== 2'b10) begin fails++; $display("FAIL fill_full got %b exp 10", {std_full, std_empty}); end
      std_rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (std_dout !== data[i]) begin fails++; $display("FAIL drain_dout got %h exp %h", std_dout, data[i]); end
         checks++; if (std_valid !== 1'b1) begin fails++; $display("FAIL drain_valid got %b exp 1", std_valid); end
      end
      std_rd_en = 1'b0;
      checks++; if ({std_empty, std_count} !== 4'b1000) begin fails++; $display("FAIL drain_empty got %b exp 1000", {std_empty, std_count}); end
      step();
      checks++; if (std_valid !== 1'b0) begin fails++; $display("FAIL drain_valid_drop got %b exp 0", std_valid); end
      checks++; if (std_dout !== 8'h44) begin fails++; $display("FAIL drain_hold got %h exp 44", std_dout); end
      checks++; if (std_unf !== 1'b0) begin fails++; $display("FAIL drain_unf got %b exp 0", std_unf); end
   endtask

   task automatic test_overflow();
      logic [7:0] expect_q [4];
      std_wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         std_din = 8'hA0 + 8'(i);
         step();
      end
      std_din = 8'h55;
      step();
      checks++; if (std_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", std_ovf); end
      checks++; if (std_count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", std_count); end
      std_din = 8'h66; std_rd_en = 1'b1;
      step();
      std_wr_en = 1'b0;
      checks++; if ({std_valid, std_dout} !== {1'b1, 8'hA0}) begin fails++; $display("FAIL full_rw_dout got %b/%h exp 1/a0", std_valid, std_dout); end
      checks++; if (std_count !== 3'd4) begin fails++; $display("FAIL full_rw_count got %0d exp 4", std_count); end
      expect_q[0] = 8'hA1; expect_q[1] = 8'hA2; expect_q[2] = 8'hA3; expect_q[3] = 8'h66;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (std_dout !== expect_q[i]) begin fails++; $display("FAIL ovf_contents got %h exp %h", std_dout, expect_q[i]); end
      end
      std_rd_en = 1'b0; std_clr_err = 1'b1;
      step();
      std_clr_err = 1'b0;
      checks++; if (std_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clr got %b exp 0", std_ovf); end
      checks++; if (std_empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got %b exp 1", std_empty); end
   endtask

   task automatic test_underflow();
      std_rd_en = 1'b1;
      step();
      checks++; if ({std_unf, std_valid} !== 2'b10) begin fails++; $display("FAIL unf_set got %b exp 10", {std_unf, std_valid}); end
      std_rd_en = 1'b0; std_clr_err = 1'b1;
      step();
      checks++; if (std_unf !== 1'b0) begin fails++; $display("FAIL unf_clr got %b exp 0", std_unf); end
      std_rd_en = 1'b1;
      step();
      checks++; if (std_unf !== 1'b1) begin fails++; $display("FAIL unf_clr_race got %b exp 1", std_unf); end
      std_clr_err = 1'b1; std_rd_en = 1'b0;
      step();
      // Read and write together at empty: write accepted, read rejected, no bypass.
      std_clr_err = 1'b0; std_wr_en = 1'b1; std_rd_en = 1'b1; std_din = 8'h7E;
      step();
      std_wr_en = 1'b0; std_rd_en = 1'b0;
      checks++; if ({std_count, std_valid, std_unf} !== 5'b00101) begin fails++; $display("FAIL empty_rw got %b exp 00101", {std_count, std_valid, std_unf}); end
      std_rd_en = 1'b1;
      step();
      std_rd_en = 1'b0; std_clr_err = 1'b1;
      checks++; if ({std_valid, std_dout} !== {1'b1, 8'h7E}) begin fails++; $display("FAIL empty_rw_data got %b/%h exp 1/7e", std_valid, std_dout); end
      step();
      std_clr_err = 1'b0;
   endtask

   task automatic test_fwft();
      fw_wr_en = 1'b1; fw_din = 8'hA5;
      step();
      fw_wr_en = 1'b0;
      checks++; if ({fw_valid, fw_dout} !== {1'b1, 8'hA5}) begin fails++; $display("FAIL fwft_show got %b/%h exp 1/a5", fw_valid, fw_dout); end
      step();
      checks++; if ({fw_valid, fw_dout, fw_count} !== {1'b1, 8'hA5, 3'd1}) begin fails++; $display("FAIL fwft_hold got %b/%h/%0d exp 1/a5/1", fw_valid, fw_dout, fw_count); end
      fw_rd_en = 1'b1;
      step();
      fw_rd_en = 1'b0;
      checks++; if ({fw_valid, fw_empty} !== 2'b01) begin fails++; $display("FAIL fwft_pop got %b exp 01", {fw_valid, fw_empty}); end
      fw_wr_en = 1'b1; fw_din = 8'hB1;
      step();
      fw_din = 8'hB2;
      step();
      fw_wr_en = 1'b0;
      checks++; if ({fw_dout, fw_count} !== {8'hB1, 3'd2}) begin fails++; $display("FAIL fwft_head got %h/%0d exp b1/2", fw_dout, fw_count); end
      fw_rd_en = 1'b1;
      step();
      checks++; if ({fw_valid, fw_dout} !== {1'b1, 8'hB2}) begin fails++; $display("FAIL fwft_next got %b/%h exp 1/b2", fw_valid, fw_dout); end
      step();
      step();
      fw_rd_en = 1'b0;
      checks++; if ({fw_valid, fw_unf} !== 2'b01) begin fails++; $display("FAIL fwft_unf got %b exp 01", {fw_valid, fw_unf}); end
   endtask

   task automatic test_wrap();
      int peak;
      peak = 0;
      for (int i = 0; i < 10; i++) begin
         std_wr_en = 1'b1; std_din = 8'(i);
         step();
         std_wr_en = 1'b0;
         if (int'(std_count) > peak) peak = int'(std_count);
         std_rd_en = 1'b1;
         step();
         std_rd_en = 1'b0;
         checks++; if ({std_valid, std_dout} !== {1'b1, 8'(i)}) begin fails++; $display("FAIL wrap_data got %b/%h exp 1/%h", std_valid, std_dout, 8'(i)); end
      end
      checks++; if (peak !== 1) begin fails++; $display("FAIL wrap_peak got %0d exp 1", peak); end
      checks++; if (std_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", std_empty); end
   endtask

   task automatic test_mid_reset();
      std_rd_en = 1'b1;
      step();
      std_rd_en = 1'b0;
      std_wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         std_din = 8'hC0 + 8'(i);
         step();
      end
      checks++; if ({std_count, std_unf} !== 4'b0111) begin fails++; $display("FAIL pre_reset got %b exp 0111", {std_count, std_unf}); end
      std_din = 8'hCF; std_reset = 1'b1;
      step();
      std_reset = 1'b0; std_wr_en = 1'b0;
      checks++; if ({std_count, std_empty, std_ae, std_af, std_full} !== 7'b0001100) begin fails++; $display("FAIL mid_reset got %b exp 0001100", {std_count, std_empty, std_ae, std_af, std_full}); end
      checks++; if ({std_ovf, std_unf, std_valid, std_dout} !== 11'b0) begin fails++; $display("FAIL mid_reset_out got %b/%h exp 000/00", {std_ovf, std_unf, std_valid}, std_dout); end
      std_rd_en = 1'b1;
      step();
      std_rd_en = 1'b0;
      checks++; if ({std_unf, std_valid} !== 2'b10) begin fails++; $display("FAIL post_reset_read got %b exp 10", {std_unf, std_valid}); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_fwft();
      test_wrap();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It generalises the team's fixed 4x8 buffer to any power-of-two depth and any data width.
- Adds exact occupancy output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Offers a selectable first-word-fall-through (FWFT) read mode.
- Used as the standard elastic buffer between datapath stages in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  reset, synchronous, active-high
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request (FWFT: pop acknowledge)
dout  out  WIDTH  read data
valid  out  1  dout holds valid data (see Behaviour)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  exact occupancy, 0..DEPTH
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset is synchronous, active-high on clk; it dominates all other inputs.
- Values after reset: pointers 0, count 0, dout 0, valid 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0. Memory contents are not reset.
- Storage: DEPTH x WIDTH array. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- rd_ok = rd_en && !empty.
- wr_ok = wr_en && (!full || rd_ok): a write at full is accepted when a read is accepted in the same cycle.
- At empty, a simultaneous read is rejected and the write is accepted. The written word is not bypassed.
- wr_ok: mem[wr_ptr] <= din; wr_ptr increments.
- rd_ok: rd_ptr increments.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- All status flags are combinational from the registered count.
- Standard mode (FWFT=0):
  - On rd_ok, dout <= mem[rd_ptr] and valid <= 1 for exactly the next cycle; otherwise valid <= 0.
  - dout holds its last value when no read occurs. Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] and valid = !empty, both combinational from registered state.
  - rd_en while valid consumes the head word.
  - A word written into an empty FIFO appears on dout/valid in the cycle after the write.
- Error flags:
  - overflow sets on wr_en && !wr_ok.
  - underflow sets on rd_en && !rd_ok.
  - Both stay set until reset or clr_err. If a set condition and clr_err occur in the same cycle, the flag is set.
  - A rejected operation changes no pointer, count or memory word.
- Threshold flags follow count exactly, including the cases AF_LEVEL=DEPTH (same as full) and AE_LEVEL=0 (same as empty).
- Reset asserted mid-operation discards all contents on the next edge; the FIFO reports empty after that edge.

Test Plan:
1. DEPTH=4, FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full per AF_LEVEL=3. Then 4 reads -> dout 0x11..0x44 each one cycle after rd_en, valid pulses, empty=1.
2. Full FIFO, wr_en=1 alone with din=0x55 -> overflow=1, count stays 4, contents unchanged. Then wr_en+rd_en together -> both accepted, count=4, head advances.
3. Empty FIFO, rd_en=1 -> underflow=1, valid=0. Assert clr_err -> underflow=0. Assert clr_err and rd_en together while empty -> underflow remains 1.
4. FWFT=1, DEPTH=4: write 0xA5 -> next cycle valid=1, dout=0xA5 with no rd_en. Then rd_en -> following cycle valid=0, empty=1.
5. Pointer wrap: run 10 write/read pairs through DEPTH=4 with data 0..9 -> output sequence 0..9 in order, count never exceeds 1.
6. Fill to count=3, assert reset for one cycle with wr_en=1 -> count=0, empty=1, almost_empty=1, flags clear, written data ignored.
